// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings (common with the ID decoder), EX-stage FSM states and defaults.
package alu_pkg;

   localparam int unsigned XLEN_DEFAULT        = 32;
   localparam int unsigned SHAMT_W_DEFAULT     = 5;
   localparam int unsigned LINK_OFFSET_DEFAULT = 4;
   localparam int unsigned ALU_OP_W            = 4;
   localparam int unsigned RD_W                = 5;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_LT   = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_JUMP = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SHL  = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_SHR  = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_NOPE = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } alu_state_e;

   function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
      return (op == ALU_SHL) || (op == ALU_SHR);
   endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative 1-bit-per-cycle logical shifter. The first bit is shifted on the start edge;
// o_done_c flags the edge on which o_result_c is the final shifted value.
module alu_iter_shifter
   import alu_pkg::*;
#(
   parameter int unsigned XLEN    = XLEN_DEFAULT,
   parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_kill,
   input  logic               i_start,
   input  logic               i_dir_right,
   input  logic [XLEN-1:0]    i_op_a,
   input  logic [SHAMT_W-1:0] i_shamt,
   output logic               o_done_c,
   output logic [XLEN-1:0]    o_result_c
);

   logic [XLEN-1:0]    r_acc;
   logic [SHAMT_W-1:0] r_cnt;
   logic               r_dir;
   logic [XLEN-1:0]    w_first;

   function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic right);
      return right ? (v >> 1) : (v << 1);
   endfunction

   always_comb begin
      w_first    = (i_shamt == '0) ? i_op_a : shift1(i_op_a, i_dir_right);
      o_result_c = i_start ? w_first : shift1(r_acc, r_dir);
      o_done_c   = i_start ? (i_shamt <= SHAMT_W'(1)) : (r_cnt == SHAMT_W'(1));
   end

   // Counter holds the number of shifts still owed after the current one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_dir <= 1'b0;
      end else if (i_kill) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_acc <= w_first;
         r_dir <= i_dir_right;
         r_cnt <= (i_shamt == '0) ? '0 : i_shamt - SHAMT_W'(1);
      end else if (r_cnt != '0) begin
         r_acc <= shift1(r_acc, r_dir);
         r_cnt <= r_cnt - SHAMT_W'(1);
      end
   end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with valid/ready handshakes and synchronous flush.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts instead of the iterative shifter.
module ex_alu_stage
   import alu_pkg::*;
#(
   parameter int unsigned XLEN        = XLEN_DEFAULT,
   parameter int unsigned SHAMT_W     = SHAMT_W_DEFAULT,
   parameter int unsigned LINK_OFFSET = LINK_OFFSET_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ALU_OP_W-1:0] in_alu_op,
   input  logic [XLEN-1:0]     in_op_a,
   input  logic [XLEN-1:0]     in_op_b,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [RD_W-1:0]     in_rd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_result,
   output logic                out_zero,
   output logic [RD_W-1:0]     out_rd
);

   alu_state_e          r_state;
   alu_state_e          w_state_nxt;
   logic [XLEN-1:0]     r_result;
   logic                r_zero;
   logic [RD_W-1:0]     r_rd;

   logic                w_accept;
   logic                w_to_shift;
   logic                w_shift_done_c;
   logic                w_load_c;
   logic [XLEN-1:0]     w_alu_c;
   logic [XLEN-1:0]     w_res_nxt_c;
   logic [RD_W-1:0]     w_rd_nxt_c;
   logic [SHAMT_W-1:0]  w_shamt;

   assign w_shamt  = in_op_b[SHAMT_W-1:0];
   assign w_accept = in_valid & in_ready;

   // Single-cycle ALU datapath.
   always_comb begin
      w_alu_c = '0;
      case (in_alu_op)
         ALU_ADD:  w_alu_c = in_op_a + in_op_b;
         ALU_SUB:  w_alu_c = in_op_a - in_op_b;
         ALU_AND:  w_alu_c = in_op_a & in_op_b;
         ALU_OR:   w_alu_c = in_op_a | in_op_b;
         ALU_XOR:  w_alu_c = in_op_a ^ in_op_b;
         ALU_LT:   w_alu_c = XLEN'($signed(in_op_a) < $signed(in_op_b));
         ALU_JUMP: w_alu_c = in_pc + XLEN'(LINK_OFFSET);
`ifdef ALU_BARREL_SHIFT_EN
         ALU_SHL:  w_alu_c = in_op_a << w_shamt;
         ALU_SHR:  w_alu_c = in_op_a >> w_shamt;
`endif
         default:  w_alu_c = '0;
      endcase
   end

`ifdef ALU_BARREL_SHIFT_EN
   assign w_to_shift     = 1'b0;
   assign w_shift_done_c = 1'b0;
   assign w_res_nxt_c    = w_alu_c;
   assign w_rd_nxt_c     = in_rd;
`else
   logic            w_is_shift;
   logic [XLEN-1:0] w_shift_res_c;
   logic [RD_W-1:0] r_shift_rd;

   assign w_is_shift = is_shift_op(in_alu_op);

   alu_iter_shifter #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_kill      (flush),
      .i_start     (w_accept & w_is_shift),
      .i_dir_right (in_alu_op == ALU_SHR),
      .i_op_a      (in_op_a),
      .i_shamt     (w_shamt),
      .o_done_c    (w_shift_done_c),
      .o_result_c  (w_shift_res_c)
   );

   // Meaningful only together with w_accept: shift needing more than one edge.
   assign w_to_shift  = w_is_shift & ~w_shift_done_c;
   assign w_res_nxt_c = ((r_state == ST_SHIFT) || w_is_shift) ? w_shift_res_c : w_alu_c;
   assign w_rd_nxt_c  = (r_state == ST_SHIFT) ? r_shift_rd : in_rd;

   // rd of the op in the shifter, published together with its result.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_shift_rd <= '0;
      else if (w_accept)
         r_shift_rd <= in_rd;
   end
`endif

   assign w_load_c = (w_accept & ~w_to_shift) | ((r_state == ST_SHIFT) & w_shift_done_c);

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Flush beats both accept and out_ready.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_HOLD: begin
               if (w_accept)
                  w_state_nxt = w_to_shift ? ST_SHIFT : ST_HOLD;
               else if ((r_state == ST_HOLD) && out_ready)
                  w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
               if (w_shift_done_c)
                  w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      in_ready  = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready));
      out_valid = (r_state == ST_HOLD);
   end

   // Result, zero flag and rd always update together; they keep stale values across a flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= '0;
         r_zero   <= 1'b1;
         r_rd     <= '0;
      end else if (!flush && w_load_c) begin
         r_result <= w_res_nxt_c;
         r_zero   <= (w_res_nxt_c == '0);
         r_rd     <= w_rd_nxt_c;
      end
   end

   assign out_result = r_result;
   assign out_zero   = r_zero;
   assign out_rd     = r_rd;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage (latency expectations follow ALU_BARREL_SHIFT_EN).
module tb_ex_alu_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_alu_op;
   logic [31:0] in_op_a;
   logic [31:0] in_op_b;
   logic [31:0] in_pc;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic [4:0]  out_rd;

   int n_vec = 0;
   int n_err = 0;

   ex_alu_stage #(.XLEN(32), .SHAMT_W(5), .LINK_OFFSET(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_alu_op  (in_alu_op),
      .in_op_a    (in_op_a),
      .in_op_b    (in_op_b),
      .in_pc      (in_pc),
      .in_rd      (in_rd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_rd     (out_rd)
   );

   always #5 clk = ~clk;

   localparam int N_SINGLE = 12;
   localparam logic [3:0]  S_OP [N_SINGLE] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd2, 4'd3,
                                               4'd4, 4'd5, 4'd12, 4'd0, 4'd1, 4'd9};
   localparam logic [31:0] S_A  [N_SINGLE] = '{32'd7, 32'd5, 32'hFFFFFFFF, 32'hDEAD, 32'hF0F0, 32'hF0,
                                               32'hFFFF0000, 32'd1, 32'h1234, 32'hFFFFFFFF, 32'd0, 32'd3};
   localparam logic [31:0] S_B  [N_SINGLE] = '{32'd5, 32'd5, 32'd1, 32'hBEEF, 32'hFF00, 32'h0F,
                                               32'hFF00FF00, 32'hFFFFFFFF, 32'h5678, 32'd2, 32'd1, 32'd4};
   localparam logic [31:0] S_PC [N_SINGLE] = '{32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0,
                                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
   localparam logic [31:0] S_EX [N_SINGLE] = '{32'd12, 32'd0, 32'd1, 32'h104, 32'hF000, 32'hFF,
                                               32'h00FFFF00, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0};

   localparam int N_SHIFT = 6;
   localparam logic [3:0]  H_OP [N_SHIFT] = '{4'd7, 4'd8, 4'd7, 4'd8, 4'd7, 4'd8};
   localparam logic [31:0] H_A  [N_SHIFT] = '{32'd1, 32'h80000000, 32'hABCD, 32'hF0, 32'd3, 32'hFFFFFFFF};
   localparam logic [31:0] H_B  [N_SHIFT] = '{32'd3, 32'd31, 32'd0, 32'd1, 32'h22, 32'd4};
   localparam logic [31:0] H_EX [N_SHIFT] = '{32'd8, 32'd1, 32'hABCD, 32'h78, 32'hC, 32'h0FFFFFFF};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [4:0] rd);
      in_valid  = 1'b1;
      in_alu_op = op;
      in_op_a   = a;
      in_op_b   = b;
      in_pc     = pc;
      in_rd     = rd;
   endtask

   // Deassert valid and scramble payload to prove operands are captured only on accept.
   task automatic idle_in();
      in_valid  = 1'b0;
      in_alu_op = 4'($urandom_range(0, 15));
      in_op_a   = $urandom();
      in_op_b   = $urandom();
      in_pc     = $urandom();
      in_rd     = 5'($urandom_range(0, 31));
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      idle_in();
      step(); step();
      rst_n = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_vec++; if (out_zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", out_zero); end
      n_vec++; if (out_result !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 0", out_result); end
      n_vec++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d expected 0", out_rd); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_single_cycle();
      out_ready = 1'b1;
      for (int i = 0; i < N_SINGLE; i++) begin
         drive(S_OP[i], S_A[i], S_B[i], S_PC[i], 5'(i + 1));
         #1;
         n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single%0d_in_ready: got %b expected 1", i, in_ready); end
         step();
         idle_in();
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single%0d_valid: got %b expected 1", i, out_valid); end
         n_vec++; if (out_result !== S_EX[i]) begin n_err++; $display("FAIL single%0d_result: got %h expected %h", i, out_result, S_EX[i]); end
         n_vec++; if (out_zero !== (S_EX[i] == 32'h0)) begin n_err++; $display("FAIL single%0d_zero: got %b expected %b", i, out_zero, (S_EX[i] == 32'h0)); end
         n_vec++; if (out_rd !== 5'(i + 1)) begin n_err++; $display("FAIL single%0d_rd: got %0d expected %0d", i, out_rd, i + 1); end
         step();
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single%0d_drain: got %b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_shift_latency();
      int lat;
      logic [4:0] sh;
      out_ready = 1'b1;
      for (int i = 0; i < N_SHIFT; i++) begin
         sh = H_B[i][4:0];
`ifdef ALU_BARREL_SHIFT_EN
         lat = 1;
`else
         lat = (sh == 5'd0) ? 1 : int'(sh);
`endif
         drive(H_OP[i], H_A[i], H_B[i], 32'h0, 5'(20 + i));
         step();
         for (int k = 1; k < lat; k++) begin
            // Valid garbage while busy must be ignored.
            idle_in();
            in_valid = 1'b1;
            #1;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL shift%0d_busy_T+%0d: got valid=%b ready=%b expected 0 0", i, k, out_valid, in_ready);
            end
            step();
         end
         idle_in();
         #1;
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL shift%0d_valid_T+%0d: got %b expected 1", i, lat, out_valid); end
         n_vec++; if (out_result !== H_EX[i]) begin n_err++; $display("FAIL shift%0d_result: got %h expected %h", i, out_result, H_EX[i]); end
         n_vec++; if (out_rd !== 5'(20 + i)) begin n_err++; $display("FAIL shift%0d_rd: got %0d expected %0d", i, out_rd, 20 + i); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive(ALU_ADD, 32'd1, 32'd1, 32'h0, 5'd6);
      step();
      idle_in();
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_result !== 32'd2 || in_ready !== 1'b0 || out_rd !== 5'd6) begin
            n_err++;
            $display("FAIL stall%0d: got valid=%b result=%h ready=%b rd=%0d expected 1 2 0 6",
                     k, out_valid, out_result, in_ready, out_rd);
         end
         step();
      end
      out_ready = 1'b1;
      drive(ALU_XOR, 32'hF, 32'h3, 32'h0, 5'd7);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL handoff_in_ready: got %b expected 1", in_ready); end
      step();
      idle_in();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL handoff_valid: got %b expected 1", out_valid); end
      n_vec++; if (out_result !== 32'hC) begin n_err++; $display("FAIL handoff_result: got %h expected c", out_result); end
      n_vec++; if (out_rd !== 5'd7) begin n_err++; $display("FAIL handoff_rd: got %0d expected 7", out_rd); end
      step();
   endtask

   task automatic test_flush_mid_shift();
      logic exp_v;
      out_ready = 1'b1;
      drive(ALU_SHL, 32'd1, 32'd10, 32'h0, 5'd3);
      step();
      idle_in();
      for (int k = 1; k <= 3; k++) begin
`ifdef ALU_BARREL_SHIFT_EN
         exp_v = (k == 1);
`else
         exp_v = 1'b0;
`endif
         n_vec++; if (out_valid !== exp_v) begin n_err++; $display("FAIL flushsh_T+%0d_valid: got %b expected %b", k, out_valid, exp_v); end
         step();
      end
      flush = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flushsh_in_ready: got %b expected 0", in_ready); end
      step();
      flush = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flushsh_after_valid: got %b expected 0", out_valid); end
      drive(ALU_ADD, 32'd2, 32'd3, 32'h0, 5'd9);
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flushsh_next_ready: got %b expected 1", in_ready); end
      step();
      idle_in();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flushsh_add_valid: got %b expected 1", out_valid); end
      n_vec++; if (out_result !== 32'd5) begin n_err++; $display("FAIL flushsh_add_result: got %h expected 5", out_result); end
      n_vec++; if (out_rd !== 5'd9) begin n_err++; $display("FAIL flushsh_add_rd: got %0d expected 9", out_rd); end
      step();
      for (int k = 0; k < 12; k++) begin
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flushsh_ghost%0d: got %b expected 0", k, out_valid); end
         step();
      end
   endtask

   task automatic test_flush_vs_accept();
      out_ready = 1'b1;
      flush = 1'b1;
      drive(ALU_ADD, 32'd4, 32'd4, 32'h0, 5'd1);
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flushacc_in_ready: got %b expected 0", in_ready); end
      step();
      flush = 1'b0;
      idle_in();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flushacc_valid: got %b expected 0", out_valid); end
      drive(ALU_ADD, 32'd9, 32'd1, 32'h0, 5'd2);
      step();
      idle_in();
      out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_result !== 32'd10) begin n_err++; $display("FAIL flushhold_pre: got valid=%b result=%h expected 1 a", out_valid, out_result); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      out_ready = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flushhold_valid: got %b expected 0", out_valid); end
      n_vec++; if (out_result !== 32'd10) begin n_err++; $display("FAIL flushhold_stale: got %h expected a", out_result); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flushhold_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_reset_mid_shift();
      out_ready = 1'b1;
      drive(ALU_SHL, 32'd1, 32'd20, 32'h0, 5'd4);
      step();
      idle_in();
      step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstsh_valid: got %b expected 0", out_valid); end
      n_vec++; if (out_zero !== 1'b1) begin n_err++; $display("FAIL rstsh_zero: got %b expected 1", out_zero); end
      n_vec++; if (out_result !== 32'h0) begin n_err++; $display("FAIL rstsh_result: got %h expected 0", out_result); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstsh_ready: got %b expected 1", in_ready); end
      for (int k = 0; k < 25; k++) begin
         step();
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstsh_ghost%0d: got %b expected 0", k, out_valid); end
      end
      drive(4'd12, 32'h77, 32'h88, 32'h40, 5'd11);
      step();
      idle_in();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL op12_valid: got %b expected 1", out_valid); end
      n_vec++; if (out_result !== 32'h0 || out_zero !== 1'b1) begin n_err++; $display("FAIL op12_result: got %h zero=%b expected 0 zero=1", out_result, out_zero); end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      idle_in();
      test_reset();
      test_single_cycle();
      test_shift_latency();
      test_back_to_back();
      test_flush_mid_shift();
      test_flush_vs_accept();
      test_reset_mid_shift();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute-stage ALU with valid/ready handshakes.
- Sits directly downstream of the ID-stage ALU-op decoder and consumes its 4-bit ALU op plus operands from the ID/EX path; the registered result feeds MEM.
- Logic/arithmetic/compare/jump-link ops complete in one cycle; shifts run on an iterative 1-bit-per-cycle shifter, back-pressuring ID.
- Synchronous flush kills in-flight work on branch redirect.

Parameters:
- XLEN, 32, datapath width.
- SHAMT_W, 5, shift-amount width (log2 XLEN).
- LINK_OFFSET, 4, value added to PC for the JUMP op.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  kill in-flight op and pending output this cycle.
- in_valid  in  1  upstream holds a valid op.
- in_ready  out  1  stage can accept this cycle.
- in_alu_op  in  4  ALU op code from the decoder.
- in_op_a  in  XLEN  operand A (rs1).
- in_op_b  in  XLEN  operand B (rs2 or immediate).
- in_pc  in  XLEN  PC of the instruction.
- in_rd  in  5  destination register index.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream consumes this cycle.
- out_result  out  XLEN  ALU result.
- out_zero  out  1  out_result == 0; used for BEQ.
- out_rd  out  5  passed-through rd.

Behaviour:
- Op encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4, LT=5, JUMP=6, SHL=7, SHR=8, NOPE=9.
  - LT: signed A<B, result {0…,1} or 0.
  - JUMP: result = in_pc + LINK_OFFSET.
  - SHR: logical.
  - NOPE and codes 10-15: result 0.
  - All arithmetic wraps modulo 2^XLEN.
  - Shift amount = in_op_b[SHAMT_W-1:0].
- Reset (rst_n=0 at clk edge):
  - state=IDLE; out_valid=0, out_result=0, out_zero=1, out_rd=0; shift counter=0.
  - Reset mid-shift abandons the op.
- FSM states:
  - IDLE: output empty.
  - SHIFT: iterating.
  - HOLD: out_valid=1, waiting on out_ready.
- in_ready = (IDLE) or (HOLD and out_ready), gated by !flush.
- Accept = in_valid & in_ready, at edge T.
  - Non-shift op: result registered at edge T, so out_valid=1 in cycle T+1 → HOLD.
  - Shift with shamt=0: A registered unchanged → HOLD.
  - Shift with shamt≥1:
    - Accumulator loaded with A shifted by 1; counter = shamt-1.
    - Counter 0 → HOLD. Otherwise → SHIFT; each cycle shifts 1 bit and decrements.
    - Enter HOLD when counter reaches 0.
    - Latency = max(1, shamt) cycles to out_valid.
- In SHIFT: out_valid=0, in_ready=0.
- HOLD:
  - out_ready=1 with a simultaneous accept loads the new op the same edge (full throughput, no bubble).
  - out_ready=1 with no accept → IDLE.
  - out_ready=0 → all outputs stable.
- out_zero and out_rd are registered alongside out_result and stay coherent with it.
- flush=1 at an edge:
  - state → IDLE, out_valid → 0.
  - Any same-cycle in_valid is not accepted.
  - Flush has priority over accept and out_ready.
  - out_result/out_rd hold their stale value (don't-care while !out_valid).
- in_* may change freely while in_ready=0. Operands are captured only on accept.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
  - Defined: shifts use a combinational barrel shifter; all ops take 1 cycle; the SHIFT state and counter are removed; in_ready = IDLE or (HOLD and out_ready).
  - Undefined: iterative shifter as above.
- Result values are identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg:
  - ALU op encoding constants (shared with the ID decoder).
  - FSM state typedef {IDLE, SHIFT, HOLD}.
  - LINK_OFFSET default.
- One natural sub-module: alu_iter_shifter (accumulator, counter, direction, start/done pulse). It is excluded when ALU_BARREL_SHIFT_EN is defined.

Test Plan:
- Single-cycle ops: ADD A=7,B=5 → 12. SUB 5-5 → 0 with out_zero=1. LT A=-1,B=1 → 1. JUMP pc=0x100 → 0x104. Each with out_valid in cycle T+1.
- Shift latency: SHL A=1,B=3 → 8, out_valid at T+3, in_ready=0 during T+1..T+2. SHR A=0x80000000,B=31 → 1 at T+31. Shamt 0 → A at T+1. With ALU_BARREL_SHIFT_EN, all at T+1.
- Back-pressure: out_ready=0 for 4 cycles after ADD 1+1 → out_result=2 held stable, in_ready=0. Then out_ready=1 with in_valid XOR 0xF,0x3 → same-edge handoff, next result 0xC, no bubble.
- Flush mid-shift: SHL B=10, flush at T+4 → out_valid never asserts for it. Next ADD 2+3 accepted the cycle after flush → 5 at +1.
- Flush vs accept: flush=1 and in_valid=1 in the same cycle → op dropped, out_valid=0 next cycle.
- Reset mid-shift: rst_n=0 one edge during SHIFT → out_valid=0, out_zero=1, in_ready=1 after release. Unknown op 12 → result 0, out_zero=1.
